dm_cache: RTL and testbench
===========================

DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning log2 number of sets (8 sets); line 32 bytes; tag width 27-S_INDEX.
REQ-002 SHALL have ports: clk  in  1  clock; reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have CPU ports: mem_address in 32 byte address; mem_read in 1; mem_write in 1; mem_byte_enable in 4; mem_wdata in 32; mem_rdata out 32; mem_resp out 1 single-cycle completion.
REQ-004 SHALL have line-side ports: pmem_address out 32 line-aligned; pmem_read out 1; pmem_write out 1; pmem_wdata out 256; pmem_rdata in 256; pmem_resp in 1 completion from the line-to-burst stage.

Function
REQ-005 SHALL be direct-mapped, write-back, write-allocate; offset [4:0], word select [4:2], index [4+S_INDEX:5], tag [31:5+S_INDEX].
REQ-006 SHALL implement states IDLE, COMPARE, WRITEBACK, FILL.
REQ-007 IDLE: on mem_read or mem_write SHALL latch address, wdata, byte enables and go to COMPARE; read and write both high SHALL be treated as write.
REQ-008 COMPARE hit (valid and tag equal): SHALL assert mem_resp for exactly that cycle, drive mem_rdata with the selected word on reads, merge enabled bytes and set dirty on writes (dirty set even if byte enable is 0000), then go to IDLE.
REQ-009 COMPARE miss: dirty -> WRITEBACK; clean -> FILL.
REQ-010 WRITEBACK SHALL hold pmem_write=1, pmem_address={old tag, index, 5'b0}, pmem_wdata=stored line until pmem_resp, then go to FILL.
REQ-011 FILL SHALL hold pmem_read=1, pmem_address={new tag, index, 5'b0} until pmem_resp; on pmem_resp SHALL write pmem_rdata, tag, valid=1, dirty=0, then go to COMPARE (which then hits).
REQ-012 Hit latency SHALL be: request seen in IDLE at cycle N, mem_resp at cycle N+1.
REQ-013 pmem_read and pmem_write SHALL never be high together and SHALL be 0 outside FILL/WRITEBACK.
REQ-014 Requester SHALL drop mem_read/mem_write in the cycle after mem_resp unless presenting a new request; a request present in IDLE is always accepted.
REQ-015 Byte lane k of mem_wdata SHALL update line bits [32*w+8k+7 : 32*w+8k], w = word select.

Reset
REQ-016 reset_n low at a clk edge SHALL force IDLE, clear all valid and dirty bits; mem_resp, pmem_read, pmem_write SHALL be 0 the following cycle; tag/data arrays not reset.
REQ-017 Reset during WRITEBACK or FILL SHALL abandon the transfer; no array write occurs for it.

Configuration
REQ-018 With DM_CACHE_PERF_EN defined, SHALL add outputs hit_count out 32 and miss_count out 32, reset to 0, saturating at 0xFFFFFFFF; a request completing without FILL increments hit_count, with FILL increments miss_count, once per request.
REQ-019 Without DM_CACHE_PERF_EN, those ports and counters SHALL be absent; behaviour otherwise identical.

Structure
REQ-020 Package dm_cache_pkg SHALL hold state enum, line width 256, offset width 5, line typedef and address-field helper constants.
REQ-021 Storage SHALL be sub-module dm_cache_array: tag, valid, dirty, data per set, one synchronous write port, combinational read by index.

Verification
REQ-022 After reset, read 0x00000104; pmem_rdata word1=0xDEADBEEF -> pmem_read at 0x00000100, no pmem_write, mem_rdata=0xDEADBEEF with mem_resp.
REQ-023 Repeat read 0x00000104 -> mem_resp exactly one cycle after acceptance, pmem_read/pmem_write stay 0.
REQ-024 Write 0x00000104 be=0011 data 0x12345678 -> mem_resp; subsequent read returns 0xDEAD5678.
REQ-025 Read 0x00001104 -> pmem_write at 0x00000100 with pmem_wdata[63:32]=0xDEAD5678, then pmem_read at 0x00001100, then mem_resp.
REQ-026 Assert reset_n low while in WRITEBACK -> pmem_write 0 next cycle; later read 0x00000104 misses (pmem_read issued, no writeback).
REQ-027 With DM_CACHE_PERF_EN, sequence of REQ-022..REQ-025 -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared types and address-field constants for the direct-mapped write-back cache.
package dm_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_e;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 256;
    localparam int OFFSET_W       = 5;
    localparam int WORD_SEL_W     = 3;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [LINE_W-1:0] line_t;

    // Overlay the enabled byte lanes of one 32-bit word onto a cache line.
    function automatic line_t mergeWord(input line_t                   line,
                                        input logic [WORD_SEL_W-1:0]   wordIdx,
                                        input logic [BYTES_PER_WORD-1:0] be,
                                        input logic [WORD_W-1:0]       data);
        line_t merged;
        merged = line;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (be[k]) begin
                merged[int'(wordIdx) * WORD_W + k * 8 +: 8] = data[k * 8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Per-set tag/valid/dirty/data storage: one synchronous write port, combinational read.
module dm_cache_array
    import dm_cache_pkg::*;
#(
    parameter int S_INDEX = 3,
    localparam int TAG_W  = ADDR_W - OFFSET_W - S_INDEX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [S_INDEX-1:0] index_i,
    input  logic               we_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic               wdirty_i,
    input  line_t              wline_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o,
    output line_t              line_o
);

    localparam int SETS = 1 << S_INDEX;

    logic [TAG_W-1:0] tag_q  [SETS];
    line_t            data_q [SETS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;

    // Only the status bits are cleared by reset; tags and data keep stale contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= wdirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[index_i]  <= wtag_i;
            data_q[index_i] <= wline_i;
        end
    end

    assign tag_o   = tag_q[index_i];
    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign line_o  = data_q[index_i];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache with 32-byte lines.
// Define DM_CACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module dm_cache
    import dm_cache_pkg::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output line_t             pmem_wdata,
    input  line_t             pmem_rdata,
    input  logic              pmem_resp
`ifdef DM_CACHE_PERF_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - OFFSET_W - S_INDEX;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [WORD_W-1:0]         wdata_q, wdata_d;
    logic [BYTES_PER_WORD-1:0] be_q, be_d;
    logic                      isWrite_q, isWrite_d;

    logic [S_INDEX-1:0]        reqIndex;
    logic [TAG_W-1:0]          reqTag;
    logic [WORD_SEL_W-1:0]     reqWord;
    logic                      hit;
    logic                      unusedByteOffset;

    logic [TAG_W-1:0]          arrTag;
    logic                      arrValid;
    logic                      arrDirty;
    line_t                     arrLine;
    logic                      arrWe;
    logic                      arrWdirty;
    line_t                     arrWline;

    assign reqIndex         = addr_q[OFFSET_W +: S_INDEX];
    assign reqTag           = addr_q[ADDR_W-1 -: TAG_W];
    assign reqWord          = addr_q[OFFSET_W-1 -: WORD_SEL_W];
    assign hit              = arrValid && (arrTag == reqTag);
    assign unusedByteOffset = ^addr_q[1:0];

    assign mem_rdata  = arrLine[int'(reqWord) * WORD_W +: WORD_W];
    assign pmem_wdata = arrLine;

    // Array writes are suppressed in a reset cycle so an abandoned fill leaves no trace.
    dm_cache_array #(
        .S_INDEX (S_INDEX)
    ) u_array (
        .clk      (clk),
        .reset_n  (reset_n),
        .index_i  (reqIndex),
        .we_i     (arrWe & reset_n),
        .wtag_i   (reqTag),
        .wdirty_i (arrWdirty),
        .wline_i  (arrWline),
        .tag_o    (arrTag),
        .valid_o  (arrValid),
        .dirty_o  (arrDirty),
        .line_o   (arrLine)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        be_q      <= be_d;
        isWrite_q <= isWrite_d;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        isWrite_d    = isWrite_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {reqTag, reqIndex, {OFFSET_W{1'b0}}};
        arrWe        = 1'b0;
        arrWdirty    = 1'b0;
        arrWline     = pmem_rdata;

        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d    = mem_address;
                    wdata_d   = mem_wdata;
                    be_d      = mem_byte_enable;
                    isWrite_d = mem_write;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    // A write hit marks the line dirty even when no byte lane is enabled.
                    if (isWrite_q) begin
                        arrWe     = 1'b1;
                        arrWdirty = 1'b1;
                        arrWline  = mergeWord(arrLine, reqWord, be_q, wdata_q);
                    end
                    state_d = IDLE;
                end else if (arrDirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {arrTag, reqIndex, {OFFSET_W{1'b0}}};
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    arrWe   = 1'b1;
                    state_d = COMPARE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DM_CACHE_PERF_EN
    logic        filled_q;
    logic [31:0] hitCount_q;
    logic [31:0] missCount_q;

    // A request counts as a miss if a fill happened anywhere between acceptance and mem_resp.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filled_q    <= 1'b0;
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                filled_q <= 1'b0;
            end else if ((state_q == FILL) && pmem_resp) begin
                filled_q <= 1'b1;
            end
            if (mem_resp) begin
                if (filled_q) begin
                    if (missCount_q != 32'hFFFF_FFFF) missCount_q <= missCount_q + 32'd1;
                end else begin
                    if (hitCount_q != 32'hFFFF_FFFF) hitCount_q <= hitCount_q + 32'd1;
                end
            end
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: random and directed requests against a behavioural cache/memory model.
// Build with DM_CACHE_PERF_EN defined to also check hit_count/miss_count.
module tb_dm_cache;

    localparam int S_INDEX = 3;
    localparam int SETS    = 1 << S_INDEX;
    localparam int TAG_W   = 27 - S_INDEX;

    typedef struct {
        logic         isRead;
        logic [31:0]  rdata;
        logic         miss;
        logic         wb;
        logic [31:0]  wbAddr;
        logic [255:0] wbData;
        logic [31:0]  fillAddr;
        int           issueCycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp  = 1'b0;
`ifdef DM_CACHE_PERF_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    dm_cache #(
        .S_INDEX (S_INDEX)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef DM_CACHE_PERF_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;
    int cycleCnt   = 0;

    always @(posedge clk) cycleCnt++;

    // Reference state: what memory should hold, plus which line each set should hold.
    logic [31:0]      refMem  [int unsigned];
    logic [31:0]      physMem [int unsigned];
    bit               refValid [SETS];
    bit               refDirty [SETS];
    logic [TAG_W-1:0] refTag   [SETS];
    logic [255:0]     refLine  [SETS];
    exp_t             expQ[$];
    exp_t             monExp;
    int               perfHits   = 0;
    int               perfMisses = 0;

    int           pmBusyCnt   = 0;
    bit           pmBusy      = 1'b0;
    int           pmForceLat  = -1;
    int           wbSeen      = 0;
    int           fillSeen    = 0;
    int           exclViol    = 0;
    logic [31:0]  lastWbAddr   = '0;
    logic [255:0] lastWbData   = '0;
    logic [31:0]  lastFillAddr = '0;
    logic [31:0]  lastRdata    = '0;

    function automatic logic [31:0] initWord(input logic [31:0] wordIdx);
        return (wordIdx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] refMemWord(input logic [31:0] wordIdx);
        return refMem.exists(wordIdx) ? refMem[wordIdx] : initWord(wordIdx);
    endfunction

    function automatic logic [31:0] physMemWord(input logic [31:0] wordIdx);
        return physMem.exists(wordIdx) ? physMem[wordIdx] : initWord(wordIdx);
    endfunction

    // Applies one request to the reference cache and returns what the DUT must do for it.
    function automatic exp_t refAccess(input logic [31:0] addr, input logic isWr,
                                       input logic [3:0] be, input logic [31:0] data);
        exp_t             e;
        int               set;
        int               w;
        logic [TAG_W-1:0] tag;
        logic [31:0]      lineWord;
        set      = int'((addr >> 5) % SETS);
        w        = int'((addr >> 2) % 8);
        tag      = TAG_W'(addr >> (5 + S_INDEX));
        lineWord = (addr >> 5) << 3;
        e.isRead     = !isWr;
        e.miss       = !(refValid[set] && refTag[set] == tag);
        e.wb         = 1'b0;
        e.wbAddr     = '0;
        e.wbData     = '0;
        e.fillAddr   = lineWord << 2;
        e.issueCycle = 0;
        if (e.miss) begin
            if (refValid[set] && refDirty[set]) begin
                e.wb     = 1'b1;
                e.wbAddr = (32'(refTag[set]) << (5 + S_INDEX)) | (32'(set) << 5);
                e.wbData = refLine[set];
                for (int i = 0; i < 8; i++) refMem[(e.wbAddr >> 2) + 32'(i)] = refLine[set][32*i +: 32];
            end
            for (int i = 0; i < 8; i++) refLine[set][32*i +: 32] = refMemWord(lineWord + 32'(i));
            refTag[set]   = tag;
            refValid[set] = 1'b1;
            refDirty[set] = 1'b0;
        end
        e.rdata = refLine[set][32*w +: 32];
        if (isWr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) refLine[set][32*w + 8*k +: 8] = data[8*k +: 8];
            end
            refDirty[set] = 1'b1;
        end
        return e;
    endfunction

    task automatic finishRun();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [3:0] be, input logic [31:0] data);
        exp_t e;
        int   waitCycles;
        @(negedge clk);
        checkOutput("idleQuiet", 256'({pmem_read, pmem_write, mem_resp}), 256'(0));
        e            = refAccess(addr, wr, be, data);
        e.issueCycle = cycleCnt;
        expQ.push_back(e);
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = data;
        waitCycles      = 0;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (!mem_resp && waitCycles < 300);
        if (!mem_resp) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL respTimeout: got no mem_resp for %h expected one within 300 cycles", addr);
            finishRun();
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Line-side memory: random latency, commits a transfer only in the cycle it responds.
    always @(negedge clk) begin
        if (pmem_read && pmem_write) exclViol++;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            pmBusy    = 1'b0;
        end else if (pmem_read || pmem_write) begin
            if (!pmBusy) begin
                pmBusy    = 1'b1;
                pmBusyCnt = (pmForceLat >= 0) ? pmForceLat : int'($urandom_range(0, 3));
            end
            if (pmBusyCnt == 0) begin
                if (pmem_write) begin
                    wbSeen++;
                    lastWbAddr = pmem_address;
                    lastWbData = pmem_wdata;
                    for (int i = 0; i < 8; i++) physMem[(pmem_address >> 2) + 32'(i)] = pmem_wdata[32*i +: 32];
                end else begin
                    fillSeen++;
                    lastFillAddr = pmem_address;
                    for (int i = 0; i < 8; i++) pmem_rdata[32*i +: 32] = physMemWord((pmem_address >> 2) + 32'(i));
                end
                pmem_resp = 1'b1;
            end else begin
                pmBusyCnt--;
            end
        end else begin
            pmBusy = 1'b0;
        end
    end

    // Monitor: every mem_resp retires the oldest expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && mem_resp === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpectedResp: got mem_resp=1 expected no pending request");
            end else begin
                monExp = expQ.pop_front();
                if (monExp.isRead) checkOutput("rdata", 256'(mem_rdata), 256'(monExp.rdata));
                checkOutput("writebackCount", 256'(wbSeen), 256'(monExp.wb));
                if (monExp.wb) begin
                    checkOutput("writebackAddr", 256'(lastWbAddr), 256'(monExp.wbAddr));
                    checkOutput("writebackData", lastWbData, monExp.wbData);
                end
                checkOutput("fillCount", 256'(fillSeen), 256'(monExp.miss));
                if (monExp.miss) checkOutput("fillAddr", 256'(lastFillAddr), 256'(monExp.fillAddr));
                else checkOutput("hitLatency", 256'(cycleCnt - monExp.issueCycle), 256'(1));
                checkOutput("pmemExclusive", 256'(exclViol), 256'(0));
                if (monExp.miss) perfMisses++;
                else perfHits++;
                lastRdata = mem_rdata;
                wbSeen    = 0;
                fillSeen  = 0;
                exclViol  = 0;
            end
        end
    end

    initial begin
        #500000;
        checkCount++;
        errorCount++;
        $display("[TB] FAIL watchdog: got no end of test expected finish within 50000 cycles");
        finishRun();
    end

    initial begin
        int               waitCycles;
        logic [31:0]      addr;
        int               kind;
        logic [TAG_W-1:0] tagPool [5];
        tagPool = '{TAG_W'(0), TAG_W'(1), TAG_W'(2), TAG_W'('h11), TAG_W'('hABC)};

        reset_n         = 1'b0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        physMem[32'h104 >> 2] = 32'hDEAD_BEEF;
        refMem[32'h104 >> 2]  = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        checkOutput("resetMemResp", 256'(mem_resp), 256'(0));
        checkOutput("resetPmemRead", 256'(pmem_read), 256'(0));
        checkOutput("resetPmemWrite", 256'(pmem_write), 256'(0));
`ifdef DM_CACHE_PERF_EN
        checkOutput("resetHitCount", 256'(hit_count), 256'(0));
        checkOutput("resetMissCount", 256'(miss_count), 256'(0));
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed sequence");
        applyStimulus(32'h0000_0104, 1'b1, 1'b0, 4'b0000, 32'h0);
        checkOutput("firstReadData", 256'(lastRdata), 256'(32'hDEAD_BEEF));
        checkOutput("firstFillAddr", 256'(lastFillAddr), 256'(32'h0000_0100));
        applyStimulus(32'h0000_0104, 1'b1, 1'b0, 4'b0000, 32'h0);
        checkOutput("repeatReadData", 256'(lastRdata), 256'(32'hDEAD_BEEF));
        applyStimulus(32'h0000_0104, 1'b0, 1'b1, 4'b0011, 32'h1234_5678);
        applyStimulus(32'h0000_1104, 1'b1, 1'b0, 4'b0000, 32'h0);
        checkOutput("evictAddr", 256'(lastWbAddr), 256'(32'h0000_0100));
        checkOutput("evictWord1", 256'(lastWbData[63:32]), 256'(32'hDEAD_5678));
        checkOutput("conflictFillAddr", 256'(lastFillAddr), 256'(32'h0000_1100));
`ifdef DM_CACHE_PERF_EN
        checkOutput("seqHitCount", 256'(hit_count), 256'(2));
        checkOutput("seqMissCount", 256'(miss_count), 256'(2));
`endif

        $display("[TB] reset during writeback");
        applyStimulus(32'h0000_1104, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D);
        pmForceLat = 20;
        @(negedge clk);
        mem_address = 32'h0000_0104;
        mem_read    = 1'b1;
        waitCycles  = 0;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (!pmem_write && waitCycles < 20);
        checkOutput("abandonWbStarted", 256'(pmem_write), 256'(1));
        mem_read = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        checkOutput("abandonPmemWrite", 256'(pmem_write), 256'(0));
        checkOutput("abandonPmemRead", 256'(pmem_read), 256'(0));
        checkOutput("abandonMemResp", 256'(mem_resp), 256'(0));
        reset_n    = 1'b1;
        pmForceLat = -1;
        for (int s = 0; s < SETS; s++) begin
            refValid[s] = 1'b0;
            refDirty[s] = 1'b0;
        end
        wbSeen     = 0;
        fillSeen   = 0;
        exclViol   = 0;
        perfHits   = 0;
        perfMisses = 0;
        @(posedge clk);
        #1;
`ifdef DM_CACHE_PERF_EN
        checkOutput("rstHitCount", 256'(hit_count), 256'(0));
        checkOutput("rstMissCount", 256'(miss_count), 256'(0));
`endif
        applyStimulus(32'h0000_0104, 1'b1, 1'b0, 4'b0000, 32'h0);
        checkOutput("afterResetData", 256'(lastRdata), 256'(32'hDEAD_5678));

        $display("[TB] random traffic");
        for (int n = 0; n < 250; n++) begin
            addr = (32'(tagPool[$urandom_range(0, 4)]) << (5 + S_INDEX))
                 | (32'($urandom_range(0, SETS - 1)) << 5)
                 | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            applyStimulus(addr, kind != 2, kind >= 2, 4'($urandom_range(0, 15)), $urandom);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboardDrained", 256'(expQ.size()), 256'(0));
`ifdef DM_CACHE_PERF_EN
        checkOutput("finalHitCount", 256'(hit_count), 256'(perfHits));
        checkOutput("finalMissCount", 256'(miss_count), 256'(perfMisses));
`endif
        finishRun();
    end

endmodule
